// File: rtl/scdata_periph_pkg.sv
// scdata_periph_pkg: shared defaults and helper functions for the periphery pipeline
package scdata_periph_pkg;
  localparam int unsigned W_DEF = 156;
  localparam int unsigned NCH_DEF = 4;
  localparam int unsigned DEPTH_DEF = 2;
  localparam int unsigned CNTW_DEF = 8;
  function automatic logic [31:0] popcount(input logic [31:0] x);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 32'(x[i]);
    return n;
  endfunction
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction
endpackage

// File: rtl/scdata_periph_stage.sv
// scdata_periph_stage: one retiming stage of NCH channels with valid scan chain
module scdata_periph_stage
  import scdata_periph_pkg::*;
#(
  parameter int unsigned W = W_DEF,
  parameter int unsigned NCH = NCH_DEF
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             se,
  input  logic             si,
  input  logic             stall,
  input  logic             flush,
  input  logic [NCH-1:0]   i_vld,
  input  logic [NCH-1:0]   i_par,
  input  logic [NCH*W-1:0] i_data,
  output logic [NCH-1:0]   o_vld,
  output logic [NCH-1:0]   o_par,
  output logic [NCH*W-1:0] o_data,
  output logic             so
);
  logic [NCH*W-1:0] r_d;
  logic [NCH-1:0]   r_v;
  logic [NCH-1:0]   r_p;
  // scan shifts only valids; flush beats stall and clears valids while data/parity still load
  always_ff @(posedge rclk) begin
    if (reset) begin
      r_d <= '0;
      r_v <= '0;
      r_p <= '0;
    end else if (se) begin
      r_v <= NCH'({r_v, si});
    end else if (flush || !stall) begin
      r_d <= i_data;
      r_p <= i_par;
      r_v <= flush ? '0 : i_vld;
    end
  end
  assign o_vld  = r_v;
  assign o_par  = r_p;
  assign o_data = r_d;
  assign so     = r_v[NCH-1];
endmodule

// File: rtl/scdata_periph_pipe.sv
// scdata_periph_pipe: parity-protected multi-channel retiming pipe with error counter
module scdata_periph_pipe
  import scdata_periph_pkg::*;
#(
  parameter int unsigned W = W_DEF,
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNTW = CNTW_DEF
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             se,
  input  logic             si,
  output logic             so,
  input  logic [NCH-1:0]   in_vld,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   err_inj,
  input  logic             stall,
  input  logic             flush,
  input  logic             err_clr,
  output logic [NCH-1:0]   out_vld,
  output logic [NCH*W-1:0] out_data,
  output logic [NCH-1:0]   par_err,
  output logic [CNTW-1:0]  err_cnt
);
  localparam logic [31:0] CMAX = 32'((64'd1 << CNTW) - 64'd1);
  logic [NCH*W-1:0] w_d [DEPTH+1];
  logic [NCH-1:0]   w_v [DEPTH+1];
  logic [NCH-1:0]   w_p [DEPTH+1];
  logic             w_s [DEPTH+1];
  logic [NCH-1:0]   w_par_in;
  logic [NCH-1:0]   w_perr;
  logic [CNTW-1:0]  r_cnt;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign w_par_in[c] = (^in_data[c*W +: W]) ^ err_inj[c];
    assign w_perr[c]   = out_vld[c] & ((^out_data[c*W +: W]) != w_p[DEPTH][c]);
  end
  assign w_d[0] = in_data;
  assign w_v[0] = in_vld;
  assign w_p[0] = w_par_in;
  assign w_s[0] = si;
  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    scdata_periph_stage #(.W(W), .NCH(NCH)) u_stage (
      .rclk  (rclk),
      .reset (reset),
      .se    (se),
      .si    (w_s[s]),
      .stall (stall),
      .flush (flush),
      .i_vld (w_v[s]),
      .i_par (w_p[s]),
      .i_data(w_d[s]),
      .o_vld (w_v[s+1]),
      .o_par (w_p[s+1]),
      .o_data(w_d[s+1]),
      .so    (w_s[s+1])
    );
  end
  // count parity errors on consumed beats, saturating; clear wins over increment
  always_ff @(posedge rclk) begin
    if (reset) r_cnt <= '0;
    else if (se) r_cnt <= r_cnt;
    else if (err_clr) r_cnt <= '0;
    else if (!stall && !flush) r_cnt <= CNTW'(sat_add(32'(r_cnt), popcount(32'(w_perr)), CMAX));
  end
  assign out_vld  = w_v[DEPTH];
  assign out_data = w_d[DEPTH];
  assign par_err  = w_perr;
  assign err_cnt  = r_cnt;
  assign so       = w_s[DEPTH];
endmodule

// File: tb/tb_scdata_periph_pipe.sv
// tb_scdata_periph_pipe: directed scoreboard bench for the periphery pipe
module tb_scdata_periph_pipe;
  localparam int W = 156, NCH = 4, DEPTH = 2, CNTW = 2, DW = W * NCH;
  localparam int CMAX = (1 << CNTW) - 1;
  typedef struct {
    logic [NCH-1:0] vld;
    logic [DW-1:0]  data;
    logic [NCH-1:0] inj;
  } beat_t;
  logic            rclk, reset, se, si, so, stall, flush, err_clr;
  logic [NCH-1:0]  in_vld, err_inj, out_vld, par_err;
  logic [DW-1:0]   in_data, out_data;
  logic [CNTW-1:0] err_cnt;
  beat_t q[$];
  int n_cmp = 0, n_bad = 0, cnt_m = 0;

  scdata_periph_pipe #(.W(W), .NCH(NCH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .rclk(rclk), .reset(reset), .se(se), .si(si), .so(so),
    .in_vld(in_vld), .in_data(in_data), .err_inj(err_inj),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .out_vld(out_vld), .out_data(out_data), .par_err(par_err), .err_cnt(err_cnt)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i += 16) r[i +: 16] = 16'($urandom);
    return r;
  endfunction

  task automatic check_all();
    chk("out_vld", DW'(out_vld), DW'(q[0].vld));
    chk("out_data", out_data, q[0].data);
    chk("par_err", DW'(par_err), DW'(q[0].vld & q[0].inj));
    chk("err_cnt", DW'(err_cnt), DW'(cnt_m));
    chk("so", DW'(so), DW'(q[0].vld[NCH-1]));
  endtask

  task automatic do_reset();
    beat_t z;
    z.vld = '0; z.data = '0; z.inj = '0;
    reset = 1'b1;
    @(posedge rclk); #1;
    reset = 1'b0;
    q.delete();
    repeat (DEPTH) q.push_back(z);
    cnt_m = 0;
    check_all();
  endtask

  task automatic step(input logic [NCH-1:0] v, input logic [DW-1:0] d, input logic [NCH-1:0] inj,
                      input logic st, input logic fl, input logic clr);
    beat_t b;
    int pe;
    in_vld = v; in_data = d; err_inj = inj; stall = st; flush = fl; err_clr = clr;
    pe = $countones(q[0].vld & q[0].inj);
    @(posedge rclk); #1;
    if (clr) cnt_m = 0;
    else if (!st && !fl) cnt_m = (cnt_m + pe > CMAX) ? CMAX : cnt_m + pe;
    b.data = d; b.inj = inj; b.vld = fl ? '0 : v;
    if (fl) foreach (q[i]) q[i].vld = '0;
    if (fl || !st) begin
      void'(q.pop_front());
      q.push_back(b);
    end
    check_all();
  endtask

  task automatic go(input logic [NCH-1:0] v, input logic [NCH-1:0] inj);
    step(v, rnd(), inj, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [7:0] ch;
    logic [7:0] pat;
    pat = 8'b10110010;
    se = 0; si = 0; stall = 0; flush = 0; err_clr = 0; in_vld = '0; in_data = '0; err_inj = '0; reset = 0;
    do_reset();
    d = rnd();
    d[W-1:0] = 156'h5A;
    step(4'b0001, d, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("lat1_vld", DW'(out_vld), DW'(4'b0000));
    go(4'b0000, 4'b0000);
    chk("lat2_vld", DW'(out_vld), DW'(4'b0001));
    chk("lat2_ch0", DW'(out_data[W-1:0]), DW'(156'h5A));
    go(4'b1111, 4'b0000);
    repeat (3) step(4'b1111, rnd(), 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("stall_hold", DW'(out_vld), DW'(4'b0000));
    go(4'b0000, 4'b0000);
    chk("stall_emerge", DW'(out_vld), DW'(4'b1111));
    go(4'b1111, 4'b0000);
    go(4'b0101, 4'b0000);
    step(4'b1111, rnd(), 4'b0000, 1'b1, 1'b1, 1'b0);
    chk("flush_vld", DW'(out_vld), DW'(4'b0000));
    repeat (3) begin
      go(4'b0000, 4'b0000);
      chk("flush_gone", DW'(out_vld), DW'(4'b0000));
    end
    go(4'b1111, 4'b1010);
    go(4'b0000, 4'b0000);
    chk("inj_perr", DW'(par_err), DW'(4'b1010));
    chk("inj_cnt0", DW'(err_cnt), DW'(0));
    go(4'b0000, 4'b0000);
    chk("inj_cnt2", DW'(err_cnt), DW'(2));
    repeat (4) go(4'b1111, 4'b1111);
    go(4'b0000, 4'b0000);
    go(4'b0000, 4'b0000);
    chk("sat_cnt", DW'(err_cnt), DW'(3));
    go(4'b1111, 4'b1111);
    go(4'b0000, 4'b0000);
    chk("sat_perr", DW'(par_err), DW'(4'b1111));
    step(4'b0000, rnd(), 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("clr_cnt", DW'(err_cnt), DW'(0));
    go(4'b1111, 4'b0000);
    step(4'b1111, rnd(), 4'b0000, 1'b0, 1'b1, 1'b0);
    go(4'b0011, 4'b0000);
    go(4'b0000, 4'b0000);
    chk("post_flush", DW'(out_vld), DW'(4'b0011));
    go(4'b1111, 4'b0000);
    go(4'b1111, 4'b0000);
    do_reset();
    go(4'b1100, 4'b0000);
    chk("rst_lat1", DW'(out_vld), DW'(4'b0000));
    go(4'b0000, 4'b0000);
    chk("rst_lat2", DW'(out_vld), DW'(4'b1100));
    go(4'b0110, 4'b0000);
    go(4'b1001, 4'b0000);
    ch = {q[0].vld, q[1].vld};
    in_vld = '0; stall = 0; flush = 0; err_clr = 0;
    se = 1'b1;
    for (int i = 0; i < 16; i++) begin
      si = (i < 8) ? pat[7-i] : 1'b0;
      @(posedge rclk); #1;
      ch = {ch[6:0], si};
      chk("scan_so", DW'(so), DW'(ch[7]));
      chk("scan_vld", DW'(out_vld), DW'(ch[7:4]));
      chk("scan_data", out_data, q[0].data);
      chk("scan_cnt", DW'(err_cnt), DW'(cnt_m));
    end
    si = 1'b1;
    do_reset();
    chk("scan_rst_so", DW'(so), DW'(0));
    se = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
